// File: rtl/id_imm_pkg.sv
// Shared definitions for the ID-stage immediate generator: opcodes, format
// codes and the decoded-entry record. Entries are built at the widest XLEN
// and truncated where they are consumed.
package id_imm_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_e            fmt;
    logic                illegal;
  } imm_entry_t;

endpackage

// File: rtl/id_imm_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// The immediate is sign-extended to XLEN_MAX; truncating it to any XLEN
// yields the correctly extended value for that width.
// Optional: define IMMGEN_CSR_ZIMM_EN to decode CSR immediate forms as ZIMM.
module id_imm_decode
  import id_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr_i,
  output imm_entry_t  entry_o
);

  logic [2:0] funct3;
  logic       sgn;

  assign funct3 = instr_i[14:12];
  assign sgn    = instr_i[31];

  // Select the immediate layout from the major opcode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned (which would infer a latch).
    entry_o = '0;
    entry_o.fmt = FMT_NONE;
    case (instr_i[6:0])
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift amounts drop the funct7 bits; RV64 needs one extra bit.
          entry_o.fmt = FMT_SHAMT;
          if (XLEN == 64) entry_o.imm = {58'b0, instr_i[25:20]};
          else            entry_o.imm = {59'b0, instr_i[24:20]};
        end else begin
          entry_o.fmt = FMT_I;
          entry_o.imm = {{52{sgn}}, instr_i[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        entry_o.fmt = FMT_I;
        entry_o.imm = {{52{sgn}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        entry_o.fmt = FMT_S;
        entry_o.imm = {{52{sgn}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        entry_o.fmt = FMT_B;
        entry_o.imm = {{51{sgn}}, sgn, instr_i[7], instr_i[30:25],
                       instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        entry_o.fmt = FMT_U;
        entry_o.imm = {{32{sgn}}, instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        entry_o.fmt = FMT_J;
        entry_o.imm = {{43{sgn}}, sgn, instr_i[19:12], instr_i[20],
                       instr_i[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
`ifdef IMMGEN_CSR_ZIMM_EN
        if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          entry_o.fmt = FMT_ZIMM;
          entry_o.imm = {59'b0, instr_i[19:15]};
        end
`else
        // CSR immediate forms carry no decoded immediate in this build.
        entry_o.fmt = FMT_NONE;
`endif
      end
      OPC_OP, OPC_FENCE: begin
        entry_o.fmt = FMT_NONE;
      end
      default: begin
        entry_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_imm_gen_pipe.sv
// Registered, handshaked immediate generator for the ID stage.
// Decodes on the way in and buffers {imm, fmt, illegal, tag} in a 2-entry
// FIFO so o_ready depends only on registered occupancy, never on i_ready.
// Optional: IMMGEN_CSR_ZIMM_EN enables ZIMM decode of CSR immediate forms.
module id_imm_gen_pipe
  import id_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fmt,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_illegal
);

  imm_entry_t       dec_entry;
  imm_entry_t       mem_q [2];
  logic [TAG_W-1:0] tag_q [2];
  imm_entry_t       rd_entry;

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;

  id_imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (i_instr),
    .entry_o (dec_entry)
  );

  assign o_ready = (count_q != 2'd2);
  assign o_valid = (count_q != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Next occupancy and pointers; flush empties the buffer and drops any push.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage update; reset has priority over flush and push.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      // NOTE: the storage itself is reset because the outputs read straight
      // from it and must show zero after reset.
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push && !i_flush) begin
        mem_q[wr_ptr_q] <= dec_entry;
        tag_q[wr_ptr_q] <= i_tag;
      end
    end
  end

  assign rd_entry  = mem_q[rd_ptr_q];
  assign o_imm     = rd_entry.imm[XLEN-1:0];
  assign o_fmt     = rd_entry.fmt;
  assign o_illegal = rd_entry.illegal;
  assign o_tag     = tag_q[rd_ptr_q];

  // Upper immediate bits are only meaningful for the widest datapath.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_imm_hi;
    assign unused_imm_hi = ^rd_entry.imm[XLEN_MAX-1:XLEN];
  end

endmodule

// File: tb/tb_id_imm_gen_pipe.sv
// Self-checking bench for id_imm_gen_pipe: directed cases plus randomized
// traffic scored against a queue-based reference built from the decode rules.
module tb_id_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [31:0]      i_instr = '0;
  logic [TAG_W-1:0] i_tag = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [XLEN-1:0]  o_imm;
  logic [2:0]       o_fmt;
  logic [TAG_W-1:0] o_tag;
  logic             o_illegal;

  id_imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_flush   (i_flush),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_instr   (i_instr),
    .i_tag     (i_tag),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_imm     (o_imm),
    .o_fmt     (o_fmt),
    .o_tag     (o_tag),
    .o_illegal (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  bit   was_rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Two's-complement interpretation of a 'bits'-wide field.
  function automatic longint sx(input longint val, input int bits);
    if (val[bits-1]) return val - (longint'(1) << bits);
    return val;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins,
                                      input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint v = 0;
    int     f3 = int'(ins[14:12]);
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    case (ins[6:0])
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          e.fmt = 3'd6;
          v = (XLEN == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          e.fmt = 3'd1;
          v = sx(longint'(ins[31:20]), 12);
        end
      end
      7'h03, 7'h67: begin
        e.fmt = 3'd1;
        v = sx(longint'(ins[31:20]), 12);
      end
      7'h23: begin
        e.fmt = 3'd2;
        v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end
      7'h63: begin
        e.fmt = 3'd3;
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        v = sx(longint'(ins[31:12]) * 4096, 32);
      end
      7'h6F: begin
        e.fmt = 3'd5;
        v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      7'h73: begin
`ifdef IMMGEN_CSR_ZIMM_EN
        if (f3 >= 5) begin
          e.fmt = 3'd7;
          v = longint'(ins[19:15]);
        end
`endif
      end
      7'h33, 7'h0F: ;
      default: e.ill = 1'b1;
    endcase
    e.imm = v[XLEN-1:0];
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    check("o_valid", {63'b0, o_valid}, {63'b0, exp_q.size() != 0});
    check("o_ready", {63'b0, o_ready}, {63'b0, exp_q.size() != 2});
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("o_imm", 64'(o_imm), 64'(e.imm));
      check("o_fmt", 64'(o_fmt), 64'(e.fmt));
      check("o_illegal", 64'(o_illegal), 64'(e.ill));
      check("o_tag", 64'(o_tag), 64'(e.tag));
    end else if (was_rst) begin
      check("rst_imm", 64'(o_imm), 64'd0);
      check("rst_fmt", 64'(o_fmt), 64'd0);
      check("rst_illegal", 64'(o_illegal), 64'd0);
      check("rst_tag", 64'(o_tag), 64'd0);
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, compare.
  task automatic cycle(input logic v, input logic [31:0] ins,
                       input logic [TAG_W-1:0] tg, input logic rdy,
                       input logic fl, input logic rs);
    bit m_push;
    bit m_pop;
    i_valid = v;
    i_instr = ins;
    i_tag   = tg;
    i_ready = rdy;
    i_flush = fl;
    i_rst   = rs;
    m_push  = v && (exp_q.size() < 2);
    m_pop   = rdy && (exp_q.size() > 0);
    @(posedge i_clk);
    if (rs) begin
      exp_q.delete();
      was_rst = 1'b1;
    end else if (fl) begin
      exp_q.delete();
      was_rst = 1'b0;
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back(ref_decode(ins, tg));
      was_rst = 1'b0;
    end
    @(negedge i_clk);
    compare_outputs();
  endtask

  task automatic push_and_check(input string name, input logic [31:0] ins,
                                input logic [31:0] exp_imm,
                                input logic [2:0] exp_fmt,
                                input logic exp_ill);
    cycle(1'b1, ins, ins, 1'b1, 1'b0, 1'b0);
    check({name, "_valid"}, {63'b0, o_valid}, 64'd1);
    check({name, "_imm"}, 64'(o_imm), 64'(exp_imm));
    check({name, "_fmt"}, 64'(o_fmt), 64'(exp_fmt));
    check({name, "_illegal"}, 64'(o_illegal), 64'(exp_ill));
    cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  logic [6:0] opc_tab [12] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
                              7'h63, 7'h67, 7'h6F, 7'h0F, 7'h73, 7'h0B};

  initial begin
    @(negedge i_clk);
    cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1);

    // Decode sweep with literal expectations.
    push_and_check("addi",  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    push_and_check("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
    push_and_check("beq",   32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0);
    push_and_check("jal",   32'h0010006F, 32'h00000800, 3'd5, 1'b0);
    push_and_check("lui",   32'h123450B7, 32'h12345000, 3'd4, 1'b0);
    push_and_check("srai",  32'h4030D093, 32'h00000003, 3'd6, 1'b0);
    push_and_check("zero",  32'h00000000, 32'h00000000, 3'd0, 1'b1);
`ifdef IMMGEN_CSR_ZIMM_EN
    push_and_check("csrrwi", 32'h0002D073, 32'h00000005, 3'd7, 1'b0);
`else
    push_and_check("csrrwi", 32'h0002D073, 32'h00000000, 3'd0, 1'b0);
`endif

    // Back-pressure: third push is held until a slot frees.
    cycle(1'b1, 32'hFFF00093, 32'd100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 32'd101, 1'b0, 1'b0, 1'b0);
    check("bp_full_ready", {63'b0, o_ready}, 64'd0);
    cycle(1'b1, 32'hFE000CE3, 32'd102, 1'b0, 1'b0, 1'b0);
    check("bp_held_tag", 64'(o_tag), 64'd100);
    cycle(1'b1, 32'hFE000CE3, 32'd102, 1'b1, 1'b0, 1'b0);
    check("bp_ready_back", {63'b0, o_ready}, 64'd1);
    check("bp_order_1", 64'(o_tag), 64'd101);
    cycle(1'b1, 32'hFE000CE3, 32'd102, 1'b1, 1'b0, 1'b0);
    check("bp_order_2", 64'(o_tag), 64'd102);
    cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
    check("bp_drained", {63'b0, o_valid}, 64'd0);

    // Flush at full occupancy with a simultaneous push.
    cycle(1'b1, 32'h123450B7, 32'd200, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0010006F, 32'd201, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFFF00093, 32'd202, 1'b0, 1'b1, 1'b0);
    check("flush_valid", {63'b0, o_valid}, 64'd0);
    check("flush_ready", {63'b0, o_ready}, 64'd1);
    cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_push_lost", {63'b0, o_valid}, 64'd0);

    // Reset mid-stream.
    cycle(1'b1, 32'h4030D093, 32'd300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 32'd301, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE000CE3, 32'd302, 1'b1, 1'b1, 1'b1);
    check("rst_mid_imm", 64'(o_imm), 64'd0);
    check("rst_mid_tag", 64'(o_tag), 64'd0);
    check("rst_mid_ready", {63'b0, o_ready}, 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic [31:0] ins;
      int          k;
      r = $urandom();
      k = $urandom_range(0, 12);
      if (k == 12) ins = r;
      else         ins = {r[31:7], opc_tab[k]};
      cycle(1'($urandom_range(0, 3) != 0), ins, $urandom(),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_imm_gen_pipe.md
Name: id_imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the ID stage.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J) and sign-extends it to XLEN.
- Classifies the instruction format and flags opcodes it cannot decode.
- Sits between IF/ID fetch output and the ID/EX register. A 2-entry output buffer absorbs back-pressure with no combinational path from i_ready to o_ready.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (typically the PC) carried alongside each instruction.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_flush  in  1  discard all buffered entries
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  block can accept an instruction this cycle
- i_instr  in  32  instruction word
- i_tag  in  TAG_W  sideband tag
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts the output entry
- o_imm  out  XLEN  sign-extended immediate
- o_fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
- o_tag  out  TAG_W  tag of the output entry
- o_illegal  out  1  opcode not decodable

Behaviour:
- Reset (i_rst high at a rising edge):
  - Buffer emptied; o_valid=0; o_ready=1.
  - o_imm, o_fmt, o_tag and o_illegal forced to 0.
  - Reset wins over every other input in that cycle.
- Handshake:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - o_valid and o_ready are driven from registered state only.
- Storage and latency:
  - 2-entry FIFO (head/tail pointers plus count 0..2); o_ready = (count != 2).
  - Latency is 1 cycle: an instruction accepted at edge N is presented at edge N+1 if the buffer was empty.
  - Decode happens before write, so the FIFO stores {imm, fmt, illegal, tag}.
  - Order is preserved.
  - Payload on o_* holds stable while o_valid && !i_ready.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - At count=2, o_ready=0, so there is no push even if a pop occurs in the same cycle.
  - Pointers wrap modulo 2.
- Flush: i_flush at an edge sets count=0 and o_valid=0. Any simultaneous push is dropped. Flush has lower priority than reset.
- Decode by i_instr[6:0]:
  - 0010011 OP-IMM:
    - funct3 001/101 -> SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. The funct7 bits are excluded.
    - All other funct3 -> I.
  - 0000011 LOAD, 1100111 JALR -> I: sext(instr[31:20]).
  - 0100011 STORE -> S: sext({instr[31:25], instr[11:7]}).
  - 1100011 BRANCH -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111 LUI, 0010111 AUIPC -> U: sext({instr[31:12], 12'b0}). This sign-extends for XLEN=64.
  - 1101111 JAL -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011 OP, 0001111 FENCE, 1110011 SYSTEM -> NONE, imm 0.
  - Any other opcode, including instr[1:0] != 11 -> NONE, imm 0, illegal=1.
- Sign extension always replicates instr[31] up to XLEN.

Optional Feature:
- Macro: IMMGEN_CSR_ZIMM_EN.
- When defined, SYSTEM (1110011) with funct3 in {101, 110, 111} yields fmt ZIMM and imm = zero-extended instr[19:15].
- When undefined, those encodings yield NONE with imm 0, and fmt code 7 is never produced.

Decomposition:
- Package id_imm_pkg holds:
  - opcode localparams;
  - imm_fmt_e enum (3-bit, values as above);
  - imm_entry_t struct parameterised by width via the package XLEN_MAX=64, truncated at the point of use.
- One sub-module, id_imm_decode, holds the purely combinational instr->{imm, fmt, illegal} decode.
- The top holds the FIFO and the handshake logic.

Test Plan:
- addi 0xFFF00093, i_ready=1 -> one cycle later o_valid=1, o_imm=0xFFFFFFFF, o_fmt=1, o_illegal=0.
- Decode sweep, each followed by a pop:
  - sw 0xFE112E23 -> 0xFFFFFFFC, fmt 2.
  - beq 0xFE000CE3 -> 0xFFFFFFF8, fmt 3.
  - jal 0x0010006F -> 0x00000800, fmt 5.
  - lui 0x123450B7 -> 0x12345000, fmt 4.
- srai 0x4030D093 -> o_imm=0x00000003, fmt 6. With XLEN=64 the same instruction also gives 0x3, and lui 0x800000B7 gives 0xFFFFFFFF80000000.
- Back-pressure:
  - With i_ready=0, push 3 back-to-back -> o_ready=0 after the 2nd accept and the 3rd is held.
  - Raise i_ready -> outputs appear in order, and o_ready returns to 1 the cycle after the first pop.
- Flush and reset:
  - With count=2, assert i_flush together with i_valid -> next cycle o_valid=0, count=0, and the pushed instruction is lost.
  - i_rst mid-stream -> all outputs 0, o_ready=1.
- 0x00000000 -> illegal=1, imm 0.
- ZIMM case: csrrwi 0x0002D073 -> with IMMGEN_CSR_ZIMM_EN, imm=0x5 and fmt 7; without it, imm 0 and fmt 0.
